// File: rtl/serial_pattern_feeder.sv
// -----------------------------------------------------------------------------
// serial_pattern_feeder
//   Parallel-to-serial stage that drives the serial input of a downstream
//   sequence detector. It accepts WIDTH-bit words through a valid/ready
//   handshake into a one-word holding buffer and shifts them out one bit per
//   clock, back to back with no idle gap. When no word is being shifted, the
//   line is held at IDLE_BIT.
//
// Parameters
//   WIDTH      word width in bits (2..32)
//   MSB_FIRST  1: din[WIDTH-1] is shifted first, 0: din[0] is shifted first
//   IDLE_BIT   level driven on sout while no word is being shifted
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   din         parallel word, sampled only on an accepting edge
//   load_valid  din is valid
//   load_ready  holding buffer empty (accept on load_valid && load_ready)
//   sout        serial data bit
//   sout_valid  sout carries a data bit rather than idle fill
//   frame_done  sout carries the last bit of a word
//   busy        shifter active or holding buffer full
// -----------------------------------------------------------------------------
module serial_pattern_feeder #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          IDLE_BIT  = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_done,
  output logic             busy
);

  localparam int unsigned     CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;

  logic             accept;
  logic             launch_ok;
  logic             word_avail;
  logic [WIDTH-1:0] launch_word;
  logic [WIDTH-1:0] shifted;

  // Handshake and launch qualifiers
  always_comb begin
    accept      = load_valid && !hold_full_q;
    launch_ok   = (state_q == ST_IDLE) || (cnt_q == CNT_LAST);
    word_avail  = hold_full_q || accept;
    // A held word always goes first; otherwise the word arriving now bypasses hold
    launch_word = hold_full_q ? hold_q : din;
  end

  // Move the next bit to the output end; vacated position is zero-filled
  always_comb begin
    if (MSB_FIRST) begin
      shifted = {sreg_q[WIDTH-2:0], 1'b0};
    end else begin
      shifted = {1'b0, sreg_q[WIDTH-1:1]};
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      sreg_q      <= '0;
      cnt_q       <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;

    if (launch_ok && word_avail) begin
      // Start a new word: first bit shows on sout in the following cycle
      state_d = ST_SHIFT;
      sreg_d  = launch_word;
      cnt_d   = '0;
      if (hold_full_q) begin
        // load_ready is low here, so no new word can arrive on this edge
        hold_full_d = 1'b0;
      end
    end else begin
      if (state_q == ST_SHIFT) begin
        if (cnt_q != CNT_LAST) begin
          sreg_d = shifted;
          cnt_d  = cnt_q + CNT_W'(1);
        end else begin
          // Last bit done and nothing queued: drop back to idle fill
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      // Word arriving while the shifter is mid-word waits in hold
      if (accept) begin
        hold_d      = din;
        hold_full_d = 1'b1;
      end
    end
  end

  // Output decode, from registers only (follows reset asynchronously)
  always_comb begin
    load_ready = !hold_full_q;
    sout_valid = (state_q == ST_SHIFT);
    sout       = IDLE_BIT;
    if (state_q == ST_SHIFT) begin
      sout = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
    end
    frame_done = (state_q == ST_SHIFT) && (cnt_q == CNT_LAST);
    busy       = (state_q == ST_SHIFT) || hold_full_q;
  end

endmodule

// File: tb/tb_serial_pattern_feeder.sv
// -----------------------------------------------------------------------------
// tb_serial_pattern_feeder
//   Self-checking bench for serial_pattern_feeder. One MSB-first and one
//   LSB-first instance share clock and reset. Expected bits are queued when a
//   word is driven and popped as the instance shifts them out. A 0110
//   detector model watches the MSB-first line.
// -----------------------------------------------------------------------------
module tb_serial_pattern_feeder;

  typedef struct packed {
    logic b;
    logic fd;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [7:0] din_m, din_l;
  logic       lv_m, lv_l;
  logic       lr_m, so_m, sv_m, fd_m, busy_m;
  logic       lr_l, so_l, sv_l, fd_l, busy_l;

  exp_t sb_m[$];
  exp_t sb_l[$];

  int n_checks;
  int n_errors;

  logic [2:0] hist;
  logic       det_z;

  serial_pattern_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) u_msb (
    .clk        (clk),
    .reset      (reset),
    .din        (din_m),
    .load_valid (lv_m),
    .load_ready (lr_m),
    .sout       (so_m),
    .sout_valid (sv_m),
    .frame_done (fd_m),
    .busy       (busy_m)
  );

  serial_pattern_feeder #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u_lsb (
    .clk        (clk),
    .reset      (reset),
    .din        (din_l),
    .load_valid (lv_l),
    .load_ready (lr_l),
    .sout       (so_l),
    .sout_valid (sv_l),
    .frame_done (fd_l),
    .busy       (busy_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Mealy 0110 detector fed by the MSB-first line
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) hist <= 3'b000;
    else        hist <= {hist[1:0], so_m};
  end
  assign det_z = ({hist, so_m} == 4'b0110);

  function automatic void push_m(input logic [7:0] w);
    for (int i = 0; i < 8; i++) sb_m.push_back('{b: w[7-i], fd: (i == 7)});
  endfunction

  function automatic void push_l(input logic [7:0] w);
    for (int i = 0; i < 8; i++) sb_l.push_back('{b: w[i], fd: (i == 7)});
  endfunction

  task automatic test_reset();
    reset = 1'b1; lv_m = 1'b1; din_m = 8'hFF; lv_l = 1'b1; din_l = 8'hFF;
    #1 reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if ({so_m, sv_m, fd_m, lr_m, busy_m} !== 5'b10010) begin
        n_errors++;
        $display("FAIL reset_outputs c=%0d got {sout,valid,fd,ready,busy}=%b want 10010",
                 c, {so_m, sv_m, fd_m, lr_m, busy_m});
      end
    end
    lv_m = 1'b0; lv_l = 1'b0; reset = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_checks++;
      if ({sv_m, busy_m, sv_l, busy_l} !== 4'b0000) begin
        n_errors++;
        $display("FAIL reset_nothing_accepted got {v_m,busy_m,v_l,busy_l}=%b want 0000",
                 {sv_m, busy_m, sv_l, busy_l});
      end
    end
  endtask

  task automatic test_single_word();
    exp_t e;
    @(negedge clk);
    din_m = 8'h06; lv_m = 1'b1; push_m(8'h06);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c <= 8) begin
        n_checks++;
        if (sv_m !== 1'b1 || sb_m.size() == 0) begin
          n_errors++;
          $display("FAIL single_valid c=%0d got %b want 1 (queued=%0d)", c, sv_m, sb_m.size());
        end else begin
          e = sb_m.pop_front();
          n_checks++;
          if (so_m !== e.b) begin
            n_errors++;
            $display("FAIL single_bit c=%0d got %b want %b", c, so_m, e.b);
          end
          n_checks++;
          if (fd_m !== e.fd) begin
            n_errors++;
            $display("FAIL single_frame_done c=%0d got %b want %b", c, fd_m, e.fd);
          end
        end
        n_checks++;
        if (det_z !== 1'(c == 8)) begin
          n_errors++;
          $display("FAIL single_detector_z c=%0d got %b want %b", c, det_z, 1'(c == 8));
        end
      end else begin
        n_checks++;
        if ({so_m, sv_m, fd_m, busy_m} !== 4'b1000) begin
          n_errors++;
          $display("FAIL single_idle c=%0d got {sout,valid,fd,busy}=%b want 1000",
                   c, {so_m, sv_m, fd_m, busy_m});
        end
      end
      lv_m = 1'b0;
    end
    n_checks++;
    if (sb_m.size() != 0) begin
      n_errors++;
      $display("FAIL single_leftover got %0d bits want 0", sb_m.size());
    end
  endtask

  // Two words; hold loaded on the second edge. toggle_din scrambles din while blocked.
  task automatic run_two_words(input logic [7:0] w1, input logic [7:0] w2,
                               input bit toggle_din, input string tag);
    exp_t e;
    @(negedge clk);
    din_m = w1; lv_m = 1'b1; push_m(w1);
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      if (c <= 16) begin
        n_checks++;
        if (sv_m !== 1'b1 || sb_m.size() == 0) begin
          n_errors++;
          $display("FAIL %s_valid c=%0d got %b want 1 (queued=%0d)", tag, c, sv_m, sb_m.size());
        end else begin
          e = sb_m.pop_front();
          n_checks++;
          if ({so_m, fd_m} !== {e.b, e.fd}) begin
            n_errors++;
            $display("FAIL %s_bit c=%0d got {sout,fd}=%b want %b", tag, c, {so_m, fd_m}, {e.b, e.fd});
          end
        end
      end else begin
        n_checks++;
        if ({so_m, sv_m} !== 2'b10) begin
          n_errors++;
          $display("FAIL %s_idle c=%0d got {sout,valid}=%b want 10", tag, c, {so_m, sv_m});
        end
      end
      n_checks++;
      if (lr_m !== 1'((c == 1) || (c >= 9))) begin
        n_errors++;
        $display("FAIL %s_load_ready c=%0d got %b want %b", tag, c, lr_m, 1'((c == 1) || (c >= 9)));
      end
      n_checks++;
      if (busy_m !== 1'(c <= 16)) begin
        n_errors++;
        $display("FAIL %s_busy c=%0d got %b want %b", tag, c, busy_m, 1'(c <= 16));
      end
      if (c == 1) begin
        din_m = w2; lv_m = 1'b1; push_m(w2);
      end else if (c <= 7) begin
        lv_m = 1'b1;
        if (toggle_din) din_m = 8'($urandom);
      end else begin
        lv_m = 1'b0;
      end
    end
    n_checks++;
    if (sb_m.size() != 0) begin
      n_errors++;
      $display("FAIL %s_leftover got %0d bits want 0", tag, sb_m.size());
    end
  endtask

  task automatic test_back_to_back();
    run_two_words(8'hA5, 8'h3C, 1'b0, "b2b");
  endtask

  task automatic test_hold_full();
    run_two_words(8'h96, 8'h4B, 1'b1, "holdfull");
  endtask

  task automatic test_lsb_first();
    exp_t e;
    @(negedge clk);
    din_l = 8'h06; lv_l = 1'b1; push_l(8'h06);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c <= 8) begin
        n_checks++;
        if (sv_l !== 1'b1 || sb_l.size() == 0) begin
          n_errors++;
          $display("FAIL lsb_valid c=%0d got %b want 1 (queued=%0d)", c, sv_l, sb_l.size());
        end else begin
          e = sb_l.pop_front();
          n_checks++;
          if ({so_l, fd_l} !== {e.b, e.fd}) begin
            n_errors++;
            $display("FAIL lsb_bit c=%0d got {sout,fd}=%b want %b", c, {so_l, fd_l}, {e.b, e.fd});
          end
        end
      end else begin
        n_checks++;
        if ({so_l, sv_l, busy_l} !== 3'b100) begin
          n_errors++;
          $display("FAIL lsb_idle got {sout,valid,busy}=%b want 100", {so_l, sv_l, busy_l});
        end
      end
      lv_l = 1'b0;
    end
  endtask

  task automatic test_reset_mid_word();
    exp_t e;
    @(negedge clk);
    din_m = 8'hF0; lv_m = 1'b1; push_m(8'hF0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      lv_m = 1'b0;
      e = sb_m.pop_front();
      n_checks++;
      if ({sv_m, so_m} !== {1'b1, e.b}) begin
        n_errors++;
        $display("FAIL midreset_pre c=%0d got {valid,sout}=%b want %b", c, {sv_m, so_m}, {1'b1, e.b});
      end
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if ({so_m, sv_m, fd_m, lr_m, busy_m} !== 5'b10010) begin
      n_errors++;
      $display("FAIL midreset_async got {sout,valid,fd,ready,busy}=%b want 10010",
               {so_m, sv_m, fd_m, lr_m, busy_m});
    end
    sb_m.delete();
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if ({so_m, sv_m, busy_m} !== 3'b100) begin
        n_errors++;
        $display("FAIL midreset_residual c=%0d got {sout,valid,busy}=%b want 100", c, {so_m, sv_m, busy_m});
      end
    end
    din_m = 8'hC3; lv_m = 1'b1; push_m(8'hC3);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      lv_m = 1'b0;
      if (c <= 8) begin
        n_checks++;
        if (sv_m !== 1'b1 || sb_m.size() == 0) begin
          n_errors++;
          $display("FAIL midreset_next_valid c=%0d got %b want 1", c, sv_m);
        end else begin
          e = sb_m.pop_front();
          n_checks++;
          if ({so_m, fd_m} !== {e.b, e.fd}) begin
            n_errors++;
            $display("FAIL midreset_next_bit c=%0d got {sout,fd}=%b want %b", c, {so_m, fd_m}, {e.b, e.fd});
          end
        end
      end else begin
        n_checks++;
        if ({so_m, sv_m} !== 2'b10) begin
          n_errors++;
          $display("FAIL midreset_next_idle got {sout,valid}=%b want 10", {so_m, sv_m});
        end
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    din_m = '0; din_l = '0; lv_m = 1'b0; lv_l = 1'b0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_lsb_first();
    test_reset_mid_word();
    test_hold_full();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached with %0d errors of %0d checks", n_errors, n_checks);
    $fatal(1);
  end

endmodule

// File: doc/serial_pattern_feeder.md
# serial_pattern_feeder

- Parallel-to-serial stage that sits directly upstream of the 0110 sequence detector and drives its serial input `x`, one bit per clock.
- Accepts WIDTH-bit words through a valid/ready handshake into a one-word holding buffer, then shifts them out back-to-back with no idle gap.
- Drives a defined idle level whenever no word is being shifted.
- Flags the last bit of each word so downstream logic can align detector hits to word boundaries.

## Interface
Parameters:
- `WIDTH`, 8: word width in bits; legal range 2..32.
- `MSB_FIRST`, 1: 1 = shift `din[WIDTH-1]` first; 0 = shift `din[0]` first.
- `IDLE_BIT`, 1: level driven on `sout` when not shifting.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `din`  in  WIDTH  parallel word; sampled only on an accepting edge.
- `load_valid`  in  1  `din` is valid.
- `load_ready`  out  1  holding buffer empty; a word is accepted on an edge where `load_valid && load_ready`.
- `sout`  out  1  serial data; connects to the detector's `x`.
- `sout_valid`  out  1  `sout` carries a data bit (not idle fill).
- `frame_done`  out  1  high during the cycle `sout` carries the last bit of a word.
- `busy`  out  1  shifter active or holding buffer full.

## Operation
- Storage:
  - shift register `sreg[WIDTH-1:0]`;
  - bit counter `cnt`, width `$clog2(WIDTH)`;
  - `active` flag;
  - holding register `hold[WIDTH-1:0]` with `hold_full` flag.
- States:
  - IDLE: `active`=0.
  - SHIFT: `active`=1, `cnt` = index of the bit currently on `sout`, 0..WIDTH-1.
- `load_ready` = `!hold_full`. It is derived from registers only, with no combinational path from `load_valid`.
- Accept: on an accepting edge, `din` is written to `hold` and `hold_full` is set.
- Launch condition L: IDLE, or SHIFT with `cnt == WIDTH-1`.
  - On an edge with L true and a word available, the shifter loads and `cnt` is set to 0.
  - The word is taken from `hold` if `hold_full`, otherwise from an accepting word on that edge (bypass).
  - The loaded word's first bit appears on `sout` in the cycle after that edge.
  - `hold` → shifter clears `hold_full`. If the same edge also accepts a new word, `hold` is rewritten and `hold_full` stays 1. This cannot occur while `hold_full` was already 1, because `load_ready` is 0 then.
- SHIFT, `cnt < WIDTH-1`: shift by one bit toward the output end and increment `cnt`.
- SHIFT, `cnt == WIDTH-1` with no word available: go to IDLE.
- Outputs, decoded from registers only:
  - `sout` = `active ? (MSB_FIRST ? sreg[WIDTH-1] : sreg[0]) : IDLE_BIT`;
  - `sout_valid` = `active`;
  - `frame_done` = `active && cnt == WIDTH-1`;
  - `busy` = `active || hold_full`.
- `din` is ignored on non-accepting edges. Changing `din` while `load_ready` = 0 has no effect.

## Timing
- Reset (asynchronous on assertion): `active`=0, `hold_full`=0, `cnt`=0, `sreg`/`hold` cleared.
- Outputs during reset: `sout`=IDLE_BIT, `sout_valid`=0, `frame_done`=0, `load_ready`=1, `busy`=0.
- Reset mid-word: the partial word and any held word are discarded, and the line returns to idle level immediately (not at the next edge). Leaving reset takes effect synchronously at the next rising edge.
- Latency: word accepted at edge k with the shifter idle → first bit on `sout` in cycle k+1, last bit in cycle k+WIDTH.
- Throughput: one bit per clock. Consecutive words are gapless when the next word is accepted no later than the edge that ends the current word's last bit.
- Acceptance while shifting: after one word is in `hold`, `load_ready` stays 0 until the edge where L moves `hold` into the shifter.
- Idle fill: with no word available, `sout`=IDLE_BIT and `sout_valid`=0.
  - With IDLE_BIT=1, the detector stays in its reset-equivalent state between words.

## Test plan
1. **Reset values.** Hold `reset`=0 for 3 cycles with `load_valid`=1 and `din`=8'hFF → `sout`=1, `sout_valid`=0, `frame_done`=0, `load_ready`=1, `busy`=0, and nothing accepted.
2. **Single word, MSB first.** Accept 8'h06 at edge k → `sout` = 0,0,0,0,0,1,1,0 in cycles k+1..k+8, `frame_done` high only in cycle k+8, `sout`=1 from cycle k+9. The downstream detector's `z` is high in cycle k+8.
3. **Back-to-back words.** `load_valid` held high with 8'hA5 then 8'h3C → 16 contiguous bits 1010010100111100 with `sout_valid` high throughout. `load_ready` is 0 from the edge that accepts 8'h3C into `hold` until the edge that launches it, then returns to 1.
4. **LSB first.** With MSB_FIRST=0, accept 8'h06 → `sout` = 0,1,1,0,0,0,0,0 with `frame_done` on the 8th bit.
5. **Reset mid-word.** Assert `reset`=0 while bit index 3 of 8'hF0 is on `sout` → `sout`=1 and `sout_valid`=0 without waiting for an edge. After release, no residual bits appear and the next accepted word starts at bit 0.
6. **Holding buffer full.** With the shifter busy and `hold` full, toggle `din` while `load_valid`=1 → no acceptance, and the held word is transmitted unchanged.
